// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory controller.
// Holds the fixed widths, access-size codes, FSM state encoding and the alignment rule.
package lsu_pkg;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 10;
    localparam int WADDR_W = 8;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RD_WAIT = 2'd1;
    localparam state_t ST_RESP    = 2'd2;

    // Size code 11 has no legal alignment, so it is reported as misaligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic m;
        case (size)
            SZ_B:    m = 1'b0;
            SZ_H:    m = off[0];
            SZ_W:    m = (off != 2'b00);
            default: m = 1'b1;
        endcase
        return m;
    endfunction
endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake plus single-port SRAM signals of the LSU memory controller.
interface lsu_mem_ctrl_if;
    import lsu_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [1:0]         req_size;
    logic               req_unsigned;
    logic [ADDR_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_wdata;
    logic               rsp_valid;
    logic [DATA_W-1:0]  rsp_rdata;
    logic               rsp_err;
    logic               mem_cen;
    logic               mem_wen;
    logic [DATA_W-1:0]  mem_bwen;
    logic [WADDR_W-1:0] mem_a;
    logic [DATA_W-1:0]  mem_d;
    logic [DATA_W-1:0]  mem_q;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_cen, mem_wen, mem_bwen, mem_a, mem_d
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_cen, mem_wen, mem_bwen, mem_a, mem_d
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational load-lane extraction: picks the byte/half addressed by the offset
// out of the SRAM word and zero- or sign-extends it to 32 bits.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] q,
    input  logic [1:0]        off,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic [DATA_W-1:0] data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    function automatic logic [31:0] ext8(input logic [7:0] v, input logic u);
        logic signed [31:0] s;
        s = {{24{v[7] & ~u}}, v};
        return s;
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] v, input logic u);
        logic signed [31:0] s;
        s = {{16{v[15] & ~u}}, v};
        return s;
    endfunction

    always_comb begin
        lane_b = 8'(q >> {off, 3'b000});
        lane_h = off[1] ? q[31:16] : q[15:0];
        case (size)
            SZ_B:    data = ext8(lane_b, uns);
            SZ_H:    data = ext16(lane_h, uns);
            default: data = q;
        endcase
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller in front of a 256x32 SRAM with bit write enables.
// Stores and rejected requests answer one cycle after accept, loads two cycles after.
module lsu_mem_ctrl
    import lsu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.slave bus
);
    state_t            state;
    logic              accept;
    logic              mis;
    logic              go;
    logic [DATA_W-1:0] bwen_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [1:0]        off_p1;
    logic [1:0]        size_p1;
    logic              uns_p1;
    logic [DATA_W-1:0] lane_p1;
    logic [DATA_W-1:0] rdata_p2;
    logic              err_p2;

    assign bus.req_ready = rst_n && (state == ST_IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign mis           = misaligned(bus.req_size, bus.req_addr[1:0]);
    assign go            = accept && !mis;

    // Accept stage: SRAM is driven in the accept cycle itself.
    always_comb begin
        bwen_p0  = '1;
        wdata_p0 = bus.req_wdata;
        case (bus.req_size)
            SZ_B: begin
                bwen_p0  = 32'h0000_00FF << {bus.req_addr[1:0], 3'b000};
                wdata_p0 = {4{bus.req_wdata[7:0]}};
            end
            SZ_H: begin
                bwen_p0  = bus.req_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wdata_p0 = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign bus.mem_cen  = !go;
    assign bus.mem_wen  = !(go && bus.req_we);
    assign bus.mem_bwen = (go && bus.req_we) ? bwen_p0 : '0;
    assign bus.mem_a    = bus.req_addr[ADDR_W-1:2];
    assign bus.mem_d    = wdata_p0;

    always_ff @(posedge clk) begin
        if (accept) begin
            off_p1  <= bus.req_addr[1:0];
            size_p1 <= bus.req_size;
            uns_p1  <= bus.req_unsigned;
        end
    end

    // Read-wait stage: SRAM output is valid now, extract using the captured offset.
    lsu_align u_align (
        .q    (bus.mem_q),
        .off  (off_p1),
        .size (size_p1),
        .uns  (uns_p1),
        .data (lane_p1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            err_p2   <= 1'b0;
            rdata_p2 <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        err_p2   <= mis;
                        rdata_p2 <= '0;
                        state    <= (mis || bus.req_we) ? ST_RESP : ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    err_p2   <= 1'b0;
                    rdata_p2 <= lane_p1;
                    state    <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Response stage: no backpressure, the pulse lasts exactly one cycle.
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_err   = err_p2 && (state == ST_RESP);
    assign bus.rsp_rdata = rdata_p2;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a behavioural SRAM, a response scoreboard and
// immediate-assertion checks of the SRAM strobes, responses, latency and reset.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          ncmp = 0;
    int          nfail = 0;
    int          cyc = 0;
    exp_t        sbq[$];
    logic [31:0] mem [256] = '{default: '0};

    lsu_mem_ctrl_if bus();

    lsu_mem_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!bus.mem_cen) begin
            if (!bus.mem_wen)
                mem[bus.mem_a] <= (mem[bus.mem_a] & ~bus.mem_bwen) | (bus.mem_d & bus.mem_bwen);
            else
                bus.mem_q <= mem[bus.mem_a];
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest outstanding expectation.
    exp_t e;
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            if (sbq.size() == 0) begin
                chk1("unexpected_rsp_valid", 1'b1, 1'b0);
            end else begin
                e = sbq.pop_front();
                chk1("rsp_err", bus.rsp_err, e.err);
                chk32("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk32("rsp_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic wait_ready(input string tag, output logic ok);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        ok = bus.req_ready;
        if (!ok) chk1({tag, "_ready_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic issue(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [9:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input logic [31:0] exp_bwen, input logic [31:0] exp_d);
        logic ok;
        wait_ready(tag, ok);
        if (!ok) return;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        #1;
        if (exp_err) begin
            chk1({tag, "_cen"}, bus.mem_cen, 1'b1);
        end else begin
            chk1({tag, "_cen"}, bus.mem_cen, 1'b0);
            chk1({tag, "_wen"}, bus.mem_wen, !we);
            chk32({tag, "_a"}, 32'(bus.mem_a), 32'(addr[9:2]));
            chk32({tag, "_bwen"}, bus.mem_bwen, exp_bwen);
            if (we) chk32({tag, "_d"}, bus.mem_d, exp_d);
        end
        sbq.push_back('{exp_err, exp_rdata, cyc + ((we || exp_err) ? 1 : 2)});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk1({tag, "_cen_idle"}, bus.mem_cen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        repeat (3) @(negedge clk);
        chk1("rst_ready", bus.req_ready, 1'b0);
        chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk1("rst_rsp_err", bus.rsp_err, 1'b0);
        chk32("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk1("rst_cen", bus.mem_cen, 1'b1);
        rst_n = 1'b1;

        issue("sw_004",  1'b1, SZ_W, 1'b0, 10'h004, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        issue("lw_004",  1'b0, SZ_W, 1'b0, 10'h004, 32'h0, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        issue("sb_006",  1'b1, SZ_B, 1'b0, 10'h006, 32'h0000_00A5, 1'b0, 32'h0, 32'h00FF_0000, 32'hA5A5_A5A5);
        issue("lb_006",  1'b0, SZ_B, 1'b0, 10'h006, 32'h0, 1'b0, 32'hFFFF_FFA5, 32'h0, 32'h0);
        issue("lbu_006", 1'b0, SZ_B, 1'b1, 10'h006, 32'h0, 1'b0, 32'h0000_00A5, 32'h0, 32'h0);
        issue("sh_00a",  1'b1, SZ_H, 1'b0, 10'h00A, 32'h0000_8001, 1'b0, 32'h0, 32'hFFFF_0000, 32'h8001_8001);
        issue("lh_00a",  1'b0, SZ_H, 1'b0, 10'h00A, 32'h0, 1'b0, 32'hFFFF_8001, 32'h0, 32'h0);
        issue("lhu_00a", 1'b0, SZ_H, 1'b1, 10'h00A, 32'h0, 1'b0, 32'h0000_8001, 32'h0, 32'h0);
        issue("sb_009",  1'b1, SZ_B, 1'b0, 10'h009, 32'h0000_007F, 1'b0, 32'h0, 32'h0000_FF00, 32'h7F7F_7F7F);
        issue("lb_009",  1'b0, SZ_B, 1'b0, 10'h009, 32'h0, 1'b0, 32'h0000_007F, 32'h0, 32'h0);
        issue("lh_008",  1'b0, SZ_H, 1'b0, 10'h008, 32'h0, 1'b0, 32'h0000_7F00, 32'h0, 32'h0);
        issue("lw_002",  1'b0, SZ_W, 1'b0, 10'h002, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0);
        issue("sh_001",  1'b1, SZ_H, 1'b0, 10'h001, 32'h1234, 1'b1, 32'h0, 32'h0, 32'h0);
        issue("sz11",    1'b0, 2'b11, 1'b0, 10'h000, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0);
        issue("lw_004b", 1'b0, SZ_W, 1'b0, 10'h004, 32'h0, 1'b0, 32'hDEA5_BEEF, 32'h0, 32'h0);

        // Continuous request: ready must open once every three cycles.
        wait_ready("b2b", ok);
        if (ok) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_size  = SZ_W;
            bus.req_addr  = 10'h004;
            for (int i = 0; i < 9; i++) begin
                chk1("b2b_ready", bus.req_ready, (i % 3) == 0);
                if (bus.req_ready) sbq.push_back('{1'b0, 32'hDEA5_BEEF, cyc + 2});
                @(negedge clk);
            end
            bus.req_valid = 1'b0;
        end

        // Reset while a load sits in RD_WAIT: the load must vanish.
        wait_ready("rst_rdwait", ok);
        if (ok) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_size  = SZ_W;
            bus.req_addr  = 10'h004;
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            @(negedge clk);
            chk1("rdwait_ready", bus.req_ready, 1'b0);
            rst_n = 1'b0;
            @(negedge clk);
            chk1("rdwait_rst_rsp_valid", bus.rsp_valid, 1'b0);
            chk1("rdwait_rst_ready", bus.req_ready, 1'b0);
            chk32("rdwait_rst_rdata", bus.rsp_rdata, 32'h0);
            rst_n = 1'b1;
            #1;
            chk1("post_rst_ready", bus.req_ready, 1'b1);
            repeat (4) @(negedge clk);
        end

        issue("lw_after_rst", 1'b0, SZ_W, 1'b0, 10'h004, 32'h0, 1'b0, 32'hDEA5_BEEF, 32'h0, 32'h0);

        repeat (5) @(negedge clk);
        chk32("scoreboard_drained", 32'(sbq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 The block SHALL have no parameters; widths are fixed: 32-bit data, 10-bit byte address (1 KB), 8-bit word address.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 req_valid  input  1  load/store request present.
REQ-005 req_ready  output  1  block accepts request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  10  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  misaligned or illegal-size request; valid with rsp_valid.
REQ-014 mem_cen, mem_wen  output  1 each  SRAM chip enable and write enable, both active-low (wen 1 = read).
REQ-015 mem_bwen  output  32  per-bit write enable, 1 = write bit.
REQ-016 mem_a  output  8  word address; mem_d  output  32  write data; mem_q  input  32  read data, valid the cycle after a read edge.

Function
REQ-017 FSM states SHALL be IDLE, RD_WAIT, RESP; req_ready SHALL be 1 only in IDLE with rst_n=1.
REQ-018 Accept = req_valid & req_ready; an accept in cycle T SHALL drive SRAM signals combinationally in T so the SRAM samples them at the end of T.
REQ-019 Misaligned SHALL be: half with addr[0]=1, word with addr[1:0]!=0, or size 11; misaligned accept SHALL keep mem_cen=1 and go IDLE->RESP with rsp_err=1, rsp_rdata=0.
REQ-020 Aligned store: mem_cen=0, mem_wen=0, mem_a=addr[9:2], IDLE->RESP; rsp_valid=1, rsp_err=0, rsp_rdata=0 in T+1.
REQ-021 Store bwen: byte sets bits [8k+7:8k], k=addr[1:0]; half sets the 16 bits of lane pair addr[1]; word sets all 32; all other bits 0.
REQ-022 Store mem_d: byte replicated 4x, half replicated 2x, word as-is.
REQ-023 Aligned load: mem_cen=0, mem_wen=1, mem_bwen=0; IDLE->RD_WAIT; the offset, size and unsigned flag SHALL be registered at accept.
REQ-024 In RD_WAIT (T+1) the block SHALL extract the lane from mem_q using the registered offset, extend it per size/unsigned, register it, and enter RESP; rsp_valid=1 in T+2.
REQ-025 RESP SHALL return to IDLE unconditionally; there is no response backpressure.
REQ-026 Outside an accept cycle mem_cen SHALL be 1, and mem_wen, mem_bwen, mem_a, mem_d SHALL be 0/1 don't-care held at mem_wen=1, mem_bwen=0.
REQ-027 Throughput SHALL be one store per 2 cycles and one load per 3 cycles; back-to-back requests are held off by req_ready.

Reset
REQ-028 While rst_n=0: state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_cen=1.
REQ-029 Reset in RD_WAIT or RESP SHALL discard the transaction with no rsp_valid; a store accepted in the cycle before reset has completed in the SRAM.

Structure
REQ-030 Shared package lsu_pkg SHALL hold the size codes (SZ_B, SZ_H, SZ_W) and the FSM state type.
REQ-031 Load lane extraction and extension SHALL live in a combinational sub-module lsu_align.

Verification
REQ-032 SW addr 0x004, data 0xDEADBEEF -> mem_a=0x01, bwen=0xFFFFFFFF, rsp_valid at T+1, err=0; LW 0x004 -> rdata 0xDEADBEEF at T+2.
REQ-033 SB addr 0x006, data 0x000000A5 -> bwen=0x00FF0000, mem_d=0xA5A5A5A5; LB 0x006 -> 0xFFFFFFA5; LBU -> 0x000000A5.
REQ-034 SH addr 0x00A, data 0x8001 -> bwen=0xFFFF0000; LH -> 0xFFFF8001; LHU -> 0x00008001.
REQ-035 LW 0x002, SH 0x001, size 11 -> mem_cen stays 1, rsp_err=1, rdata=0 at T+1.
REQ-036 req_valid held high continuously -> req_ready low in RD_WAIT/RESP, loads accepted every 3 cycles.
REQ-037 rst_n low during RD_WAIT -> no rsp_valid, state IDLE, req_ready=1 on the first cycle after rst_n returns high.
